des_round_sequencer: RTL and testbench

- Iterative single-DES engine controller: accepts a 64-bit block and a 64-bit key, then runs the 16 Feistel rounds, one round per clock.
- Owns IP/FP, PC-1/PC-2 and the C/D rotation schedule, plus the L/R registers and round counter.
- The combinational f-function (32-bit R, 48-bit subkey -> 32-bit) sits outside the block and is driven through ports, so it can be shared or swapped.
- Sits between the block-level valid/ready stream and the fFunction datapath.

---
 rtl/des_round_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_des_round_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_sequencer.sv
`default_nettype none
// ============================================================================
// des_round_sequencer : iterative single-DES round controller, one round per
// clock, f-function external. Optional reverse key schedule: DES_DECRYPT_EN.
// Revision 1.0
// ============================================================================
module des_round_sequencer #(
  parameter int ROUNDS = 16,
  parameter int CNT_W  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] in_block_i,
  input  logic [63:0] in_key_i,
  input  logic        in_decrypt_i,
  output logic [31:0] f_r_o,
  output logic [47:0] f_k_o,
  input  logic [31:0] f_res_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] out_block_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Tables use DES numbering: entry value n selects DES bit n (bit 1 = MSB).
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - IP_T[k])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - FP_T[k])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int k = 0; k < 56; k++) y[6'(55 - k)] = x[6'(64 - PC1_T[k])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[6'(56 - PC2_T[k])];
    return y;
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      l_q, r_q, fr_hold_q, r_new_d;
  logic [27:0]      c_q, d_q, c_rot_d, d_rot_d;
  logic [47:0]      fk_hold_q, subkey_d;
  logic [63:0]      out_block_q;
  logic             in_ready_q, out_valid_q;
  logic             one_shift_d, last_round_d;

  assign one_shift_d  = (cnt_q == '0) || (cnt_q == CNT_W'(1)) ||
                        (cnt_q == CNT_W'(8)) || (cnt_q == CNT_W'(15));
  assign last_round_d = (cnt_q == CNT_W'(ROUNDS - 1));

`ifdef DES_DECRYPT_EN
  logic mode_q;

  // Decrypt walks the schedule backwards: C16/D16 equal C0/D0, so round 0 needs no shift.
  always_comb begin
    if (!mode_q) begin
      c_rot_d = one_shift_d ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
      d_rot_d = one_shift_d ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
    end else if (cnt_q == '0) begin
      c_rot_d = c_q;
      d_rot_d = d_q;
    end else begin
      c_rot_d = one_shift_d ? {c_q[0], c_q[27:1]} : {c_q[1:0], c_q[27:2]};
      d_rot_d = one_shift_d ? {d_q[0], d_q[27:1]} : {d_q[1:0], d_q[27:2]};
    end
  end
`else
  logic unused_decrypt;
  assign unused_decrypt = in_decrypt_i;

  always_comb begin
    c_rot_d = one_shift_d ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
    d_rot_d = one_shift_d ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
  end
`endif

  assign subkey_d = perm_pc2({c_rot_d, d_rot_d});
  assign r_new_d  = l_q ^ f_res_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      fr_hold_q   <= '0;
      fk_hold_q   <= '0;
      out_block_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef DES_DECRYPT_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i && in_ready_q) begin
            {l_q, r_q} <= perm_ip(in_block_i);
            {c_q, d_q} <= perm_pc1(in_key_i);
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_ROUND;
`ifdef DES_DECRYPT_EN
            mode_q     <= in_decrypt_i;
`endif
          end
        end
        S_ROUND: begin
          l_q       <= r_q;
          r_q       <= r_new_d;
          c_q       <= c_rot_d;
          d_q       <= d_rot_d;
          cnt_q     <= cnt_q + 1'b1;
          fr_hold_q <= r_q;
          fk_hold_q <= subkey_d;
          if (last_round_d) begin
            // Preoutput swap: {R16, L16}, where L16 is the current R.
            out_block_q <= perm_fp({r_new_d, r_q});
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outside ROUND the f-function ports hold the last round's operands.
  assign f_r_o       = (state_q == S_ROUND) ? r_q      : fr_hold_q;
  assign f_k_o       = (state_q == S_ROUND) ? subkey_d : fk_hold_q;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_block_o = out_block_q;
  assign busy_o      = (state_q == S_ROUND);

endmodule
`default_nettype wire

// File: tb/tb_des_round_sequencer.sv
`default_nettype none
// ============================================================================
// tb_des_round_sequencer : directed DES vectors, scoreboard queue + monitor.
// Revision 1.0
// ============================================================================
module tb_des_round_sequencer;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] C2 = 64'h0000000000000000;

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, y;
    logic [5:0]  six;
    for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[i])];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[6'(47 - 6 * b) -: 6];
      s[5'(31 - 4 * b) -: 4] = 4'(SBOX[9'(b * 64 + 16 * int'({six[5], six[0]}) + int'(six[4:1]))]);
    end
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[i])];
    return y;
  endfunction

`ifndef DES_DECRYPT_EN
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Reference encryption; the final permutation is applied as the inverse of IP.
  function automatic logic [63:0] ref_des_enc(input logic [63:0] key, input logic [63:0] blk);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    logic [63:0] x, y;
    logic [31:0] l, r, t;
    int          sh;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1_T[i])];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 64; i++) x[6'(63 - i)] = blk[6'(64 - IP_T[i])];
    l = x[63:32];
    r = x[31:0];
    for (int rd = 1; rd <= 16; rd++) begin
      sh = (rd == 1 || rd == 2 || rd == 9 || rd == 16) ? 1 : 2;
      for (int j = 0; j < sh; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
      t = r;
      r = l ^ des_f(r, k);
      l = t;
    end
    x = {r, l};
    for (int i = 0; i < 64; i++) y[6'(64 - IP_T[i])] = x[6'(63 - i)];
    return y;
  endfunction
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
  logic [63:0] in_block, in_key, out_block;
  logic [31:0] f_r, f_res;
  logic [47:0] f_k;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          last_ho = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb f_res = des_f(f_r, f_k);

  des_round_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_block_i   (in_block),
    .in_key_i     (in_key),
    .in_decrypt_i (in_decrypt),
    .f_r_o        (f_r),
    .f_k_o        (f_k),
    .f_res_i      (f_res),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_block_o  (out_block),
    .busy_o       (busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: a handshake seen here completes at the following rising edge.
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) timeout("unexpected_output");
      else check("result", out_block, sb.pop_front());
      last_ho = cyc + 1;
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input logic [63:0] key, input logic [63:0] blk, input logic dec,
                      input logic [63:0] exp, input bit hold);
    int guard = 0;
    in_valid   = 1'b1;
    in_key     = key;
    in_block   = blk;
    in_decrypt = dec;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      timeout("accept");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    last_acc = cyc;
    sb.push_back(exp);
    if (!hold) begin
      in_valid = 1'b0;
      in_block = '0;
      in_key   = '0;
    end
  endtask

  task automatic wait_out(output int seen_at);
    int guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    seen_at = cyc;
    if (!out_valid) timeout("out_valid");
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) timeout("in_ready");
  endtask

  initial begin
    int          rise;
    logic [63:0] exp_dec;
    in_valid   = 1'b0;
    in_block   = '0;
    in_key     = '0;
    in_decrypt = 1'b0;
    out_ready  = 1'b1;
    rst_n      = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_block", out_block, 64'd0);
    check("rst_f_r", 64'(f_r), 64'd0);
    check("rst_f_k", 64'(f_k), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Classic vector with a probe of the first two rounds
    send(K1, P1, 1'b0, C1, 1'b0);
    check("r0_f_r", 64'(f_r), 64'hF0AAF0AA);
    check("r0_f_k", 64'(f_k), 64'h1B02EFFC7072);
    check("r0_f_res", 64'(f_res), 64'h234AA9BB);
    check("r0_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("r1_f_r", 64'(f_r), 64'hEF4A6544);
    wait_out(rise);
    check("latency", 64'(rise - last_acc), 64'd16);
    wait_ready();

    // Output held under back-pressure
    out_ready = 1'b0;
    send(K2, P2, 1'b0, C2, 1'b0);
    wait_out(rise);
    for (int k = 0; k < 5; k++) begin
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_out_block", out_block, C2);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_ready();

`ifdef DES_DECRYPT_EN
    exp_dec = P1;
`else
    exp_dec = ref_des_enc(K1, C1);
`endif
    send(K1, C1, 1'b1, exp_dec, 1'b0);
    wait_out(rise);
    wait_ready();

    // Asynchronous reset in round 7 discards the block
    send(K2, P2, 1'b0, C2, 1'b0);
    repeat (7) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_busy", 64'(busy), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(K1, P1, 1'b0, C1, 1'b0);
    wait_out(rise);
    wait_ready();

    // Back-to-back with in_valid held high
    send(K1, P1, 1'b0, C1, 1'b1);
    send(K2, P2, 1'b0, C2, 1'b1);
    in_valid = 1'b0;
    check("b2b_accept_gap", 64'(last_acc - last_ho), 64'd1);
    wait_out(rise);
    wait_ready();
    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
